// File: rtl/req_pend_ctrl.sv
// rtl/req_pend_ctrl.sv - sticky request capture and owner hold in front of the ps4 priority selector
module req_pend_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req_in,
  input  logic [3:0] sel_gnt,
  input  logic       done,
  output logic [3:0] req,
  output logic       en,
  output logic [3:0] owner,
  output logic       owner_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Last BUSY cycle index; the counter is cleared at grant, so this bounds BUSY to TIMEOUT cycles.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    pending;
  logic [3:0]    pending_nxt;
  logic [3:0]    owner_nxt;
  logic          owner_valid_nxt;
  logic          timeout_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [3:0]    gnt_masked;
  logic [3:0]    pick;
  logic [3:0]    clr;
  logic [3:0]    rep;

  // Keeps only the highest set bit, so a malformed multi-hot grant still yields one owner.
  function automatic logic [3:0] top_bit(input logic [3:0] v);
    logic [3:0] r;
    r = 4'b0000;
    if (v[3])      r = 4'b1000;
    else if (v[2]) r = 4'b0100;
    else if (v[1]) r = 4'b0010;
    else if (v[0]) r = 4'b0001;
    return r;
  endfunction

  assign req = pending;
  assign en  = (state == IDLE) && (pending != 4'b0000);

  // The selector's answer is only trusted while enabled, and only for bits we actually posted.
  assign gnt_masked = en ? (sel_gnt & pending) : 4'b0000;
  assign pick       = top_bit(gnt_masked);

  // Next-state and next-output decode for the IDLE/BUSY ownership FSM.
  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    owner_valid_nxt = owner_valid;
    cnt_nxt         = cnt;
    timeout_nxt     = 1'b0;
    clr             = 4'b0000;
    rep             = 4'b0000;
    case (state)
      IDLE: begin
        if (pick != 4'b0000) begin
          owner_nxt       = pick;
          owner_valid_nxt = 1'b1;
          clr             = pick;
          cnt_nxt         = '0;
          state_nxt       = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          owner_nxt       = 4'b0000;
          owner_valid_nxt = 1'b0;
          state_nxt       = IDLE;
        end else if (cnt == CNT_LAST) begin
          // Abort: drop ownership and re-post the request so it is retried.
          owner_nxt       = 4'b0000;
          owner_valid_nxt = 1'b0;
          timeout_nxt     = 1'b1;
          rep             = owner;
          state_nxt       = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt       = IDLE;
        owner_nxt       = 4'b0000;
        owner_valid_nxt = 1'b0;
      end
    endcase
    // New pulses win over the clear of the same bit, so a coincident pulse stays pending.
    pending_nxt = (pending & ~clr) | req_in | rep;
  end

  // State register plus all registered outputs; reset drops everything including pending work.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= 4'b0000;
      owner       <= 4'b0000;
      owner_valid <= 1'b0;
      timeout     <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      owner       <= owner_nxt;
      owner_valid <= owner_valid_nxt;
      timeout     <= timeout_nxt;
      cnt         <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_req_pend_ctrl.sv
// tb/tb_req_pend_ctrl.sv - vector table, corner sequences and randomized model check for req_pend_ctrl
module tb_req_pend_ctrl;

  localparam int TIMEOUT = 15;
  localparam int CW      = 4;

  logic       clock;
  logic       reset;
  logic [3:0] req_in;
  logic [3:0] sel_gnt;
  logic       done;
  logic [3:0] req;
  logic       en;
  logic [3:0] owner;
  logic       owner_valid;
  logic       timeout;

  logic [3:0] junk;
  logic [3:0] extra;

  int checks;
  int errors;

  // reference model state: pending set, owner index (-1 = none), BUSY cycles used
  logic [3:0] m_pending;
  int         m_owner;
  int         m_elapsed;
  logic       m_timeout;

  typedef struct {
    logic       rst;
    logic [3:0] ri;
    logic       d;
    logic [3:0] req;
    logic       en;
    logic [3:0] own;
    logic       v;
    logic       to;
  } vec_t;

  vec_t tbl[17];

  req_pend_ctrl #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_in     (req_in),
    .sel_gnt    (sel_gnt),
    .done       (done),
    .req        (req),
    .en         (en),
    .owner      (owner),
    .owner_valid(owner_valid),
    .timeout    (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // downstream fixed-priority selector; garbage when disabled
  always_comb begin
    sel_gnt = junk;
    if (en) begin
      sel_gnt = extra;
      if (req[3])      sel_gnt = sel_gnt | 4'b1000;
      else if (req[2]) sel_gnt = sel_gnt | 4'b0100;
      else if (req[1]) sel_gnt = sel_gnt | 4'b0010;
      else if (req[0]) sel_gnt = sel_gnt | 4'b0001;
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_tick(input logic r, input logic [3:0] ri, input logic d);
    logic [3:0] grant;
    logic [3:0] repost;
    grant  = 4'b0000;
    repost = 4'b0000;
    if (r) begin
      m_pending = 4'b0000;
      m_owner   = -1;
      m_elapsed = 0;
      m_timeout = 1'b0;
      return;
    end
    m_timeout = 1'b0;
    if (m_owner < 0) begin
      for (int i = 3; i >= 0; i--) begin
        if (m_pending[i]) begin
          grant[i]  = 1'b1;
          m_owner   = i;
          m_elapsed = 0;
          break;
        end
      end
    end else begin
      m_elapsed++;
      if (d) begin
        m_owner = -1;
      end else if (m_elapsed == TIMEOUT) begin
        repost[m_owner] = 1'b1;
        m_owner         = -1;
        m_timeout       = 1'b1;
      end
    end
    m_pending = (m_pending & ~grant) | ri | repost;
  endtask

  task automatic check_model(input string tag);
    logic [3:0] e_own;
    e_own = 4'b0000;
    if (m_owner >= 0) e_own[m_owner] = 1'b1;
    check({tag, "_req"},   req,                 m_pending);
    check({tag, "_en"},    {3'b000, en},        {3'b000, (m_owner < 0) && (m_pending != 4'b0000)});
    check({tag, "_owner"}, owner,               e_own);
    check({tag, "_valid"}, {3'b000, owner_valid}, {3'b000, m_owner >= 0});
    check({tag, "_tmo"},   {3'b000, timeout},   {3'b000, m_timeout});
  endtask

  task automatic step(input logic r, input logic [3:0] ri, input logic d);
    reset  = r;
    req_in = ri;
    done   = d;
    junk   = 4'($urandom);
    @(posedge clock);
    model_tick(r, ri, d);
    @(negedge clock);
  endtask

  initial begin
    int vcnt;
    int tcnt;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    req_in    = 4'b0000;
    done      = 1'b0;
    junk      = 4'b0000;
    extra     = 4'b0000;
    m_pending = 4'b0000;
    m_owner   = -1;
    m_elapsed = 0;
    m_timeout = 1'b0;

    //            rst  req_in   done  req      en    owner    v     to
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'b0110, 1'b0, 4'b0110, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0, 4'b0100, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 4'b0010, 1'b0, 4'b1010, 1'b0, 4'b1000, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 4'b0000, 1'b1, 4'b1010, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0, 4'b1000, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};

    @(negedge clock);
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst, tbl[i].ri, tbl[i].d);
      check($sformatf("tbl%0d_req", i),   req,                   tbl[i].req);
      check($sformatf("tbl%0d_en", i),    {3'b000, en},          {3'b000, tbl[i].en});
      check($sformatf("tbl%0d_owner", i), owner,                 tbl[i].own);
      check($sformatf("tbl%0d_valid", i), {3'b000, owner_valid}, {3'b000, tbl[i].v});
      check($sformatf("tbl%0d_tmo", i),   {3'b000, timeout},     {3'b000, tbl[i].to});
    end

    // timeout and retry on bit 0
    step(1'b0, 4'b0001, 1'b0);
    check_model("to_post");
    vcnt = 0;
    tcnt = 0;
    for (int i = 0; i < TIMEOUT + 1; i++) begin
      step(1'b0, 4'b0000, 1'b0);
      check_model("to_run");
      if (owner_valid) vcnt++;
      if (timeout) begin
        tcnt++;
        check("to_repost_req", req, 4'b0001);
      end
    end
    check("to_valid_cycles", 4'(vcnt), 4'd15);
    check("to_pulse_count",  4'(tcnt), 4'd1);
    step(1'b0, 4'b0000, 1'b0);
    check("to_regrant_owner", owner, 4'b0001);
    check("to_pulse_gone", {3'b000, timeout}, 4'b0000);
    step(1'b0, 4'b0000, 1'b1);
    check_model("to_release");

    // done collides with the last BUSY cycle
    step(1'b0, 4'b0001, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    check("col_grant", owner, 4'b0001);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      step(1'b0, 4'b0000, 1'b0);
      check_model("col_run");
    end
    step(1'b0, 4'b0000, 1'b1);
    check("col_tmo",   {3'b000, timeout},     4'b0000);
    check("col_req",   req,                   4'b0000);
    check("col_valid", {3'b000, owner_valid}, 4'b0000);
    step(1'b0, 4'b0000, 1'b0);
    check("col_no_retry_req", req,          4'b0000);
    check("col_no_retry_en",  {3'b000, en}, 4'b0000);

    // reset in the middle of a service with two requests pending
    step(1'b0, 4'b0011, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0010, 1'b0);
    check("mr_pending", req, 4'b0011);
    check("mr_busy", owner, 4'b0010);
    step(1'b1, 4'b0000, 1'b0);
    check("mr_req",   req,   4'b0000);
    check("mr_owner", owner, 4'b0000);
    check("mr_flags", {1'b0, en, owner_valid, timeout}, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0000, 1'b0);
      check("mr_idle", {1'b0, en, owner_valid, timeout}, 4'b0000);
    end
    step(1'b0, 4'b0100, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    check("mr_new_grant", owner, 4'b0100);
    step(1'b0, 4'b0000, 1'b1);
    check_model("mr_release");

    // randomized traffic, including multi-hot selector answers and stray resets
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] ri;
      logic       d;
      logic       r;
      ri    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      d     = ($urandom_range(0, 7) == 0);
      r     = ($urandom_range(0, 199) == 0);
      extra = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      step(r, ri, d);
      check_model("rnd");
    end
    extra = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
